// File: rtl/updown_seq_ctrl.sv
// Command-driven sequencer for a small up/down counter: accepts move-to-target
// or clear commands and drives counter reset/enable/direction one step at a time.
module updown_seq_ctrl #(
    parameter int WIDTH   = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_target,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_clear,
    input  logic               abort,
    output logic               cnt_rst,
    output logic               cnt_step,
    output logic               cnt_dir,
    output logic [WIDTH-1:0]   pos,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        STEP  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE  = 1;
    localparam logic [DWELL_W-1:0] DWELL_ZERO = 0;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   target;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dir_q;
    logic               accept;
    logic               step_up;
    logic [WIDTH-1:0]   pos_stepped;

    // Never wraps: target is always strictly on the step_up side of pos in STEP.
    function automatic logic [WIDTH-1:0] step_pos(input logic [WIDTH-1:0] p, input logic up);
        return up ? p + 1'b1 : p - 1'b1;
    endfunction

    assign accept      = cmd_valid && (state == IDLE);
    assign step_up     = target > pos;
    assign pos_stepped = step_pos(pos, step_up);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_clear)
                        state_nxt = CLEAR;
                    else if (cmd_target == pos)
                        state_nxt = DONE;
                    else
                        state_nxt = STEP;
                end
            end
            CLEAR: state_nxt = DONE;
            STEP: begin
                if (pos_stepped == target)
                    state_nxt = DONE;
                else if (dwell == DWELL_ZERO)
                    state_nxt = STEP;
                else
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (dwell_cnt <= DWELL_ONE)
                    state_nxt = STEP;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE)
            state_nxt = IDLE;
    end

    // Abort suppresses every strobe in the cycle it is seen; cnt_dir holds otherwise.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        cnt_rst   = 1'b0;
        cnt_step  = 1'b0;
        cnt_dir   = dir_q;
        done      = 1'b0;
        case (state)
            CLEAR: cnt_rst = !abort;
            STEP: begin
                cnt_step = !abort;
                if (!abort)
                    cnt_dir = step_up;
            end
            DONE:    done = !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos       <= '0;
            target    <= '0;
            dwell     <= '0;
            dwell_cnt <= '0;
            dir_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !cmd_clear) begin
                        target <= cmd_target;
                        dwell  <= cmd_dwell;
                    end
                end
                CLEAR: begin
                    if (!abort)
                        pos <= '0;
                end
                STEP: begin
                    if (!abort) begin
                        pos       <= pos_stepped;
                        dir_q     <= step_up;
                        dwell_cnt <= dwell;
                    end
                end
                WAIT: begin
                    if (!abort)
                        dwell_cnt <= dwell_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl: per-cycle expected output vectors are queued
// when a command is issued and popped/compared on each falling edge.
module tb_updown_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_target;
    logic [3:0] cmd_dwell;
    logic       cmd_clear;
    logic       abort;
    logic       cnt_rst;
    logic       cnt_step;
    logic       cnt_dir;
    logic [2:0] pos;
    logic       busy;
    logic       done;

    logic [8:0] obs;
    logic [8:0] expq[$];
    logic [2:0] m_pos;
    logic       m_dir;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;

    updown_seq_ctrl #(.WIDTH(3), .DWELL_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_dwell(cmd_dwell), .cmd_clear(cmd_clear),
        .abort(abort),
        .cnt_rst(cnt_rst), .cnt_step(cnt_step), .cnt_dir(cnt_dir),
        .pos(pos), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {cnt_rst, cnt_step, cnt_dir, pos, busy, done, cmd_ready};

    function automatic logic [8:0] mk(input logic r, input logic s, input logic d,
                                      input logic [2:0] p, input logic b,
                                      input logic dn, input logic rdy);
        return {r, s, d, p, b, dn, rdy};
    endfunction

    task automatic check(input string tag, input logic [8:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (rst,step,dir,pos[3],busy,done,ready)",
                   tag, obs, expv);
        end
    endtask

    // Expected trace of a move: k steps, dwell idle cycles between them, DONE, IDLE.
    task automatic push_move(input logic [2:0] t, input int w);
        logic [2:0] p;
        logic       d;
        int         guard;
        p = m_pos;
        if (t != m_pos) begin
            d     = (t > m_pos);
            m_dir = d;
            guard = 0;
            while (guard < 16) begin
                expq.push_back(mk(1'b0, 1'b1, d, p, 1'b1, 1'b0, 1'b0));
                p = d ? p + 3'd1 : p - 3'd1;
                if (p == t) break;
                for (int i = 0; i < w; i++)
                    expq.push_back(mk(1'b0, 1'b0, d, p, 1'b1, 1'b0, 1'b0));
                guard++;
            end
        end
        expq.push_back(mk(1'b0, 1'b0, m_dir, t, 1'b1, 1'b1, 1'b0));
        expq.push_back(mk(1'b0, 1'b0, m_dir, t, 1'b0, 1'b0, 1'b1));
        m_pos = t;
    endtask

    task automatic push_clear();
        expq.push_back(mk(1'b1, 1'b0, m_dir, m_pos, 1'b1, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 1'b0, m_dir, 3'd0, 1'b1, 1'b1, 1'b0));
        expq.push_back(mk(1'b0, 1'b0, m_dir, 3'd0, 1'b0, 1'b0, 1'b1));
        m_pos = 3'd0;
    endtask

    // Called just after a rising edge while IDLE; scrambles inputs once accepted.
    task automatic issue(input logic clr, input logic [2:0] t, input logic [3:0] w);
        cmd_clear  = clr;
        cmd_target = t;
        cmd_dwell  = w;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_clear  = 1'b0;
        cmd_target = ~t;
        cmd_dwell  = 4'd0;
    endtask

    task automatic drain(input string tag, input int n);
        int k;
        k = (n < 0) ? expq.size() : n;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (expq.size() != 0)
                check(tag, expq.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_clear  = 1'b0;
        cmd_target = 3'd0;
        cmd_dwell  = 4'd0;
        abort      = 1'b0;
        m_pos      = 3'd0;
        m_dir      = 1'b0;
        #12;
        check("reset", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_after_reset", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));

        push_move(3'd5, 0);
        issue(1'b0, 3'd5, 4'd0);
        drain("up5_dwell0", -1);

        push_move(3'd2, 2);
        issue(1'b0, 3'd2, 4'd2);
        drain("down2_dwell2", -1);

        push_move(3'd7, 0);
        issue(1'b0, 3'd7, 4'd0);
        drain("up7", -1);
        push_clear();
        issue(1'b1, 3'd5, 4'd3);
        drain("clear_from7", -1);

        push_move(3'd3, 0);
        issue(1'b0, 3'd3, 4'd0);
        drain("up3", -1);
        push_move(3'd3, 3);
        issue(1'b0, 3'd3, 4'd3);
        drain("equal_target", -1);

        push_clear();
        issue(1'b1, 3'd0, 4'd0);
        drain("clear_from3", -1);

        // Abort in the WAIT after the second step of a 0->6 move with dwell 1.
        expq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
        issue(1'b0, 3'd6, 4'd1);
        drain("abort_pre", 3);
        abort = 1'b1;
        expq.push_back(mk(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0));
        drain("abort_wait", 1);
        for (int i = 0; i < 3; i++)
            expq.push_back(mk(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1));
        drain("abort_idle", 1);
        abort = 1'b0;
        drain("abort_idle", -1);
        m_pos = 3'd2;
        m_dir = 1'b1;

        push_move(3'd4, 0);
        abort = 1'b1;
        issue(1'b0, 3'd4, 4'd0);
        abort = 1'b0;
        drain("abort_with_valid", -1);

        push_clear();
        issue(1'b1, 3'd0, 4'd0);
        drain("clear_from4", -1);

        expq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
        expq.push_back(mk(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0));
        issue(1'b0, 3'd6, 4'd0);
        drain("pre_async_rst", 3);
        check("step_at_3", mk(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
        expq.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_pos = 3'd0;
        m_dir = 1'b0;
        check("post_rst_idle", mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
        push_move(3'd2, 0);
        issue(1'b0, 3'd2, 4'd0);
        drain("after_rst", -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
